// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   fetch_state_e    : sequencer FSM states
//   addr_t           : 64-bit byte address
//   RESET_PC_DEFAULT : default first fetch address after reset
package riscv_fetch_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned LINE_W = 64;

  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_REQ   = 3'd0,
    ST_WAIT  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DROP  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  localparam addr_t RESET_PC_DEFAULT = 64'h0;

  // Byte address of the 8-byte line holding a.
  function automatic addr_t line_addr(input addr_t a);
    return a & ~addr_t'(7);
  endfunction

  // Byte address of the 4-byte word holding a.
  function automatic addr_t word_addr(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Two-slot fetched-line register with slot-select mux.
//   clk, reset : clock, async active-high reset (clears the line)
//   load, data : capture a full 64-bit line from the bus
//   clear      : discard buffered words (redirect)
//   sel        : slot to present (0 = [31:0], 1 = [63:32])
//   word_c     : selected slot of the line as it will be after this edge,
//                so the caller can register it in the same cycle
module fetch_line_buf
  import riscv_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [LINE_W-1:0] data,
  input  logic              sel,
  output logic [ILEN-1:0]   word_c
);

  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] line_d;

  // Next line contents; load wins over clear.
  always_comb begin
    line_d = line;
    if (load) begin
      line_d = data;
    end else if (clear) begin
      line_d = '0;
    end
  end

  assign word_c = sel ? line_d[LINE_W-1:ILEN] : line_d[ILEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else begin
      line <= line_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests 8-byte lines over a single-outstanding
// bus, splits each line into two 32-bit instructions and hands them to the
// decoder with a valid/ready handshake. Redirects restart fetch at a new PC,
// discarding buffered words and, if needed, one in-flight response beat.
//   clk, reset          : clock, async active-high reset
//   bus_req/_addr/_ack  : line read request, aligned address, acceptance
//   bus_resp_valid/data : response beat
//   redirect_valid/pc   : restart fetch
//   ir_valid/ir/ir_pc   : instruction offered to decoder, ir_ready accepts
//   halted              : fetch stopped on a zero word
// Optional build macro FETCH_HALT_ON_ZERO_EN: a zero instruction word is not
// offered; fetch halts until the next redirect.
module fetch_sequencer
  import riscv_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
)
(
  input  logic              clk,
  input  logic              reset,
  output logic              bus_req,
  output logic [XLEN-1:0]   bus_req_addr,
  input  logic              bus_req_ack,
  input  logic              bus_resp_valid,
  input  logic [LINE_W-1:0] bus_resp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              ir_valid,
  output logic [ILEN-1:0]   ir,
  output logic [XLEN-1:0]   ir_pc,
  input  logic              ir_ready,
  output logic              halted
);

  fetch_state_e    state;
  fetch_state_e    state_d;
  addr_t           pc;
  addr_t           pc_d;
  logic            buf_load;
  logic            buf_clear;
  logic [ILEN-1:0] word_c;
  logic            xfer_c;
  logic            halt_now_c;
  logic            next_zero_c;
  addr_t           redirect_tgt_c;

  assign xfer_c         = ir_valid & ir_ready;
  assign redirect_tgt_c = word_addr(redirect_pc);

`ifdef FETCH_HALT_ON_ZERO_EN
  // In DRAIN, ir always holds the selected slot, valid or not.
  assign halt_now_c  = (ir == '0);
  assign next_zero_c = (word_c == '0);
`else
  assign halt_now_c  = 1'b0;
  assign next_zero_c = 1'b0;
`endif

  fetch_line_buf u_line_buf (
    .clk    (clk),
    .reset  (reset),
    .load   (buf_load),
    .clear  (buf_clear),
    .data   (bus_resp_data),
    .sel    (pc_d[2]),
    .word_c (word_c)
  );

  // Next state, next pc, line buffer control.
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt_c;
          buf_clear = 1'b1;
          // An accepted request must have its response dropped.
          state_d   = bus_req_ack ? ST_DROP : ST_REQ;
        end else if (bus_req_ack) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt_c;
          buf_clear = 1'b1;
          state_d   = bus_resp_valid ? ST_REQ : ST_DROP;
        end else if (bus_resp_valid) begin
          buf_load = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Redirect decides pc/state even when a transfer happens alongside.
        if (redirect_valid) begin
          pc_d      = redirect_tgt_c;
          buf_clear = 1'b1;
          state_d   = ST_REQ;
        end else if (halt_now_c) begin
          state_d = ST_HALT;
        end else if (xfer_c) begin
          pc_d    = pc + addr_t'(4);
          state_d = pc[2] ? ST_REQ : ST_DRAIN;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt_c;
          buf_clear = 1'b1;
        end
        if (bus_resp_valid) begin
          state_d = ST_REQ;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          pc_d      = redirect_tgt_c;
          buf_clear = 1'b1;
          state_d   = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State, pc and registered outputs derived from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      bus_req      <= 1'b1;
      bus_req_addr <= line_addr(RESET_PC);
      ir_valid     <= 1'b0;
      ir           <= '0;
      ir_pc        <= '0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      bus_req      <= (state_d == ST_REQ);
      bus_req_addr <= line_addr(pc_d);
      ir_valid     <= (state_d == ST_DRAIN) && !next_zero_c;
      if (state_d == ST_DRAIN) begin
        ir    <= word_c;
        ir_pc <= pc_d;
      end
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else begin
      halted <= (state_d == ST_HALT);
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-004 SHALL have port bus_req, output, 1 bit, line read request.
REQ-005 SHALL have port bus_req_addr, output, 64 bits, 8-byte-aligned line address.
REQ-006 SHALL have port bus_req_ack, input, 1 bit, request accepted this cycle.
REQ-007 SHALL have port bus_resp_valid, input, 1 bit, response data valid.
REQ-008 SHALL have port bus_resp_data, input, 64 bits, line data; [31:0] is the lower word.
REQ-009 SHALL have port redirect_valid, input, 1 bit, restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc, input, 64 bits, new fetch PC.
REQ-011 SHALL have port ir_valid, output, 1 bit, instruction offered to the decoder.
REQ-012 SHALL have port ir, output, 32 bits, instruction word.
REQ-013 SHALL have port ir_pc, output, 64 bits, PC of ir.
REQ-014 SHALL have port ir_ready, input, 1 bit, decoder accepts ir.
REQ-015 SHALL have port halted, output, 1 bit, fetch stopped.

Function
REQ-016 SHALL implement FSM states REQ, WAIT, DRAIN, DROP, HALT.
REQ-017 SHALL drive bus_req=1 only in REQ, with bus_req_addr={pc[63:3],3'b000} held stable until bus_req_ack.
REQ-018 SHALL move REQ->WAIT on bus_req_ack; at most one request is outstanding.
REQ-019 SHALL, in WAIT on bus_resp_valid, capture the line, select slot pc[2], and enter DRAIN; ir_valid rises the next cycle.
REQ-020 SHALL, in DRAIN, drive ir from the selected slot and ir_pc=pc, with both stable while ir_valid=1 and ir_ready=0.
REQ-021 SHALL, on a transfer (ir_valid & ir_ready), advance pc by 4; slot 0 -> slot 1 stays in DRAIN; slot 1 -> REQ next cycle.
REQ-022 SHALL, on redirect_valid, load pc={redirect_pc[63:2],2'b00}, clear ir_valid the next cycle, and discard buffered words.
REQ-023 SHALL route redirect as: REQ without ack -> REQ with the new address (bus permits an unacked address change on redirect); REQ with ack, or WAIT without resp -> DROP; WAIT with resp, DRAIN, DROP, HALT -> REQ (DROP stays DROP until resp).
REQ-024 SHALL, in DROP, discard the next bus_resp_valid beat and then enter REQ.
REQ-025 SHALL count a same-cycle transfer and redirect as a consumed instruction, with redirect deciding the next state and pc.
REQ-026 SHALL drive ir_valid=0 in REQ, WAIT, DROP and HALT.
REQ-027 SHALL wrap pc modulo 2^64 without special handling.

Reset
REQ-028 SHALL, while reset=1, force state REQ, pc=RESET_PC, ir_valid=0, ir=0, ir_pc=0, halted=0, and line buffer=0; bus_req=1 in the first cycle after release.
REQ-029 SHALL abandon any in-flight request on reset; stale responses are the bus's responsibility.

Configuration
REQ-030 SHALL, with FETCH_HALT_ON_ZERO_EN defined, hold ir_valid=0 when the selected slot is 32'h0 in DRAIN, enter HALT next cycle, and set halted=1 until a redirect.
REQ-031 SHALL, without FETCH_HALT_ON_ZERO_EN, pass a zero word as an ordinary instruction, tie halted=0, and leave HALT unreachable.

Structure
REQ-032 SHALL place the FSM state enum, the 64-bit address typedef and the RESET_PC default in shared package riscv_fetch_pkg.
REQ-033 SHALL place the two-slot line register and slot-select mux in sub-module fetch_line_buf.

Verification
REQ-034 Reset release, RESET_PC=0, ack on cycle 1, resp 64'hAAAA0001_00000013 on cycle 3, ir_ready=1 -> ir 32'h00000013 @pc 0, then 32'hAAAA0001 @pc 4, then bus_req addr 8.
REQ-035 redirect_pc=64'h104 during DRAIN -> next request addr 64'h100, first ir taken from upper slot with ir_pc 64'h104.
REQ-036 Redirect in WAIT before resp -> next beat discarded (DROP), then request to the new line; no ir_valid in between.
REQ-037 ir_ready=0 for 5 cycles in DRAIN -> ir/ir_pc unchanged, exactly one transfer when ready rises.
REQ-038 With FETCH_HALT_ON_ZERO_EN, line 64'h00000000_00000013 -> one transfer (0x13), then halted=1 and no bus_req until redirect.
REQ-039 Reset asserted mid-WAIT -> all outputs at reset values asynchronously; bus_req to RESET_PC after release.
